// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: load/store size codes and
// the states of the memory dump FSM.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE      = 2'b00;
    localparam logic [1:0] SZ_HALF      = 2'b01;
    localparam logic [1:0] SZ_WORD      = 2'b11;
    localparam int         UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'b00,
        DUMP_READ = 2'b01,
        DUMP_SEND = 2'b10,
        DUMP_DONE = 2'b11
    } dump_state_e;

endpackage

// File: rtl/mem_access_unit_data_memory.sv
// Word-organised data memory: byte-lane write enables, asynchronous read
// port A for loads, registered read port B for the debug dump.
module mem_access_unit_data_memory #(
    parameter int NB        = 32,
    parameter int MEM_DEPTH = 64,
    parameter int NB_ADDR   = $clog2(MEM_DEPTH)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NB/8-1:0]     wr_be_i,
    input  logic [NB_ADDR-1:0]  wr_addr_i,
    input  logic [NB-1:0]       wr_data_i,
    input  logic [NB_ADDR-1:0]  rd_addr_a_i,
    output logic [NB-1:0]       rd_data_a_o,
    input  logic                rd_en_b_i,
    input  logic [NB_ADDR-1:0]  rd_addr_b_i,
    output logic [NB-1:0]       rd_data_b_o
);
    localparam int LANES = NB / 8;

    logic [NB-1:0] mem_q [MEM_DEPTH];
    logic [NB-1:0] rd_b_q;

    // Port B reads the pre-write contents, so a same-edge store is seen on the next read.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_b_q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_be_i[l]) begin
                    mem_q[wr_addr_i][8*l +: 8] <= wr_data_i[8*l +: 8];
                end
            end
            if (rd_en_b_i) begin
                rd_b_q <= mem_q[rd_addr_b_i];
            end
        end
    end

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = rd_b_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: sized loads/stores with extension and alignment check, branch
// select, and a valid/ready dump of the whole data memory while halted.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NB        = 32,
    parameter int MEM_DEPTH = 64,
    parameter int NB_ADDR   = $clog2(MEM_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic [NB-1:0]      i_alu_result,
    input  logic [NB-1:0]      i_write_data,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_word_size,
    input  logic               i_branch,
    input  logic               i_cero,
    output logic [NB-1:0]      o_read_data,
    output logic               o_misaligned,
    output logic               o_pc_src,
    input  logic               i_dump_start,
    input  logic               i_dump_ready,
    output logic               o_dump_valid,
    output logic [NB-1:0]      o_dump_data,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic               o_dump_busy,
    output logic               o_dump_done
);
    localparam int LANES = NB / 8;
    localparam logic [NB_ADDR-1:0] LAST_WORD = NB_ADDR'(MEM_DEPTH - 1);
    typedef logic [LANES-1:0] lane_t;

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         offset;
    logic [1:0]         size;
    logic               is_unsigned;
    logic               fault;
    logic               store_en;
    lane_t              wr_be;
    logic [NB-1:0]      wr_data;
    logic [NB-1:0]      rd_word;
    logic [NB-1:0]      rd_shifted;
    logic [NB-1:0]      rd_data_b;
    logic               rd_en_b;
    logic               unused_addr_bits;

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] ptr_q, ptr_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;

    assign word_idx         = i_alu_result[NB_ADDR+1:2];
    assign offset           = i_alu_result[1:0];
    assign size             = i_word_size[1:0];
    assign is_unsigned      = i_word_size[UNSIGNED_BIT];
    assign unused_addr_bits = ^i_alu_result[NB-1:NB_ADDR+2];

    always_comb begin
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = offset[0];
            SZ_WORD: fault = (offset != 2'b00);
            default: fault = 1'b1;
        endcase
    end

    assign o_misaligned = (i_mem_read | i_mem_write) & fault;
    assign store_en     = i_step & i_mem_write & ~o_misaligned;
    assign o_pc_src     = i_branch & i_cero;

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        wr_be   = '0;
        wr_data = '0;
        case (size)
            SZ_BYTE: begin
                wr_be   = lane_t'(1) << offset;
                wr_data = {LANES{i_write_data[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = lane_t'(3) << offset;
                wr_data = {(NB/16){i_write_data[15:0]}};
            end
            SZ_WORD: begin
                wr_be   = '1;
                wr_data = i_write_data;
            end
            default: ;
        endcase
        if (!store_en) begin
            wr_be = '0;
        end
    end

    assign rd_shifted = rd_word >> {offset, 3'b000};

    always_comb begin
        o_read_data = '0;
        if (i_mem_read && !fault) begin
            case (size)
                SZ_BYTE: o_read_data = {{(NB-8){~is_unsigned & rd_shifted[7]}}, rd_shifted[7:0]};
                SZ_HALF: o_read_data = {{(NB-16){~is_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
                SZ_WORD: o_read_data = rd_word;
                default: o_read_data = '0;
            endcase
        end
    end

    mem_access_unit_data_memory #(
        .NB        (NB),
        .MEM_DEPTH (MEM_DEPTH),
        .NB_ADDR   (NB_ADDR)
    ) u_data_memory (
        .clk_i       (i_clk),
        .reset_i     (i_reset),
        .wr_be_i     (wr_be),
        .wr_addr_i   (word_idx),
        .wr_data_i   (wr_data),
        .rd_addr_a_i (word_idx),
        .rd_data_a_o (rd_word),
        .rd_en_b_i   (rd_en_b),
        .rd_addr_b_i (ptr_q),
        .rd_data_b_o (rd_data_b)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= DUMP_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
        end
    end

    // Port B only loads in READ, so its output register holds the word through backpressure.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        rd_en_b = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (i_dump_start) begin
                    ptr_d   = '0;
                    state_d = DUMP_READ;
                end
            end
            DUMP_READ: begin
                rd_en_b = 1'b1;
                addr_d  = ptr_q;
                state_d = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (i_dump_ready) begin
                    if (ptr_q == LAST_WORD) begin
                        state_d = DUMP_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = DUMP_READ;
                    end
                end
            end
            DUMP_DONE: state_d = DUMP_IDLE;
            default:   state_d = DUMP_IDLE;
        endcase
    end

    assign o_dump_valid = (state_q == DUMP_SEND);
    assign o_dump_busy  = (state_q != DUMP_IDLE);
    assign o_dump_done  = (state_q == DUMP_DONE);
    assign o_dump_data  = rd_data_b;
    assign o_dump_addr  = addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array reference model with a
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_mem_access_unit;
    localparam int NB        = 32;
    localparam int MEM_DEPTH = 64;
    localparam int NB_ADDR   = 6;
    localparam int NBYTES    = MEM_DEPTH * 4;

    logic               clk;
    logic               i_reset, i_step, i_mem_read, i_mem_write, i_branch, i_cero;
    logic [NB-1:0]      i_alu_result, i_write_data;
    logic [2:0]         i_word_size;
    logic               i_dump_start, i_dump_ready;
    logic [NB-1:0]      o_read_data, o_dump_data;
    logic               o_misaligned, o_pc_src, o_dump_valid, o_dump_busy, o_dump_done;
    logic [NB_ADDR-1:0] o_dump_addr;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [NBYTES];
    int  exp_addr   = 0;
    bit  model_busy = 0;
    bit  hs_seen    = 0;
    bit  final_prev = 0;
    bit  chk_en     = 0;
    int  done_cnt   = 0;

    mem_access_unit dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_step       (i_step),
        .i_alu_result (i_alu_result),
        .i_write_data (i_write_data),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_word_size  (i_word_size),
        .i_branch     (i_branch),
        .i_cero       (i_cero),
        .o_read_data  (o_read_data),
        .o_misaligned (o_misaligned),
        .o_pc_src     (o_pc_src),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_addr  (o_dump_addr),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int sz_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_fault(input logic [NB-1:0] a, input logic [2:0] ws);
        int n;
        n = sz_bytes(ws[1:0]);
        if (n == 0) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [NB-1:0] model_load(input logic [NB-1:0] a, input logic [2:0] ws);
        int n, base;
        logic [63:0] v;
        n    = sz_bytes(ws[1:0]);
        base = int'(a % NBYTES);
        v    = '0;
        for (int i = 0; i < n; i++) v = v | (64'(mb[base+i]) << (8*i));
        if (!ws[2] && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v[NB-1:0];
    endfunction

    function automatic logic [NB-1:0] model_word(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    // Reference model: byte-addressed memory plus a count of words delivered.
    always @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
            exp_addr   = 0;
            model_busy = 0;
        end else begin
            if (i_step && i_mem_write && !model_fault(i_alu_result, i_word_size)) begin
                int base;
                base = int'(i_alu_result % NBYTES);
                for (int i = 0; i < sz_bytes(i_word_size[1:0]); i++)
                    mb[base+i] = i_write_data[8*i +: 8];
            end
            if (hs_seen) begin
                if (exp_addr == MEM_DEPTH - 1) model_busy = 0;
                exp_addr++;
            end
            if (i_dump_start && !model_busy) begin
                model_busy = 1;
                exp_addr   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NB-1:0] exp_rd;
            bit            flt;
            flt    = model_fault(i_alu_result, i_word_size);
            exp_rd = (i_mem_read && !flt) ? model_load(i_alu_result, i_word_size) : '0;
            check("read_data", o_read_data, exp_rd);
            check("misaligned", NB'(o_misaligned), NB'((i_mem_read | i_mem_write) & flt));
            check("pc_src", NB'(o_pc_src), NB'(i_branch & i_cero));
            check("dump_done", NB'(o_dump_done), NB'(final_prev));
            check("dump_busy", NB'(o_dump_busy), NB'(model_busy | final_prev));
            if (o_dump_done) done_cnt++;
            if (o_dump_valid) begin
                check("dump_addr", NB'(o_dump_addr), NB'(exp_addr));
                check("dump_data", o_dump_data, model_word(exp_addr));
            end
            hs_seen    = o_dump_valid && i_dump_ready && !i_reset;
            final_prev = hs_seen && (exp_addr == MEM_DEPTH - 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit rd, input bit wr, input bit step, input logic [2:0] ws,
                          input logic [NB-1:0] a, input logic [NB-1:0] wd);
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_step       = step;
        i_word_size  = ws;
        i_alu_result = a;
        i_write_data = wd;
        #1;
    endtask

    initial begin
        int cnt0;
        bit seen;
        i_reset = 1; i_step = 0; i_mem_read = 0; i_mem_write = 0; i_branch = 0; i_cero = 0;
        i_alu_result = '0; i_write_data = '0; i_word_size = 3'b011;
        i_dump_start = 0; i_dump_ready = 0;
        repeat (3) tick();
        check("rst_valid", NB'(o_dump_valid), 0);
        check("rst_busy", NB'(o_dump_busy), 0);
        check("rst_done", NB'(o_dump_done), 0);
        check("rst_data", o_dump_data, 0);
        check("rst_addr", NB'(o_dump_addr), 0);
        i_reset = 0;
        chk_en  = 1;
        tick();

        access(1, 1, 1, 3'b011, 32'h10, 32'hDEADBEEF);
        tick();
        access(1, 0, 0, 3'b011, 32'h10, 0);
        check("word_load", o_read_data, 32'hDEADBEEF);
        check("word_mis", NB'(o_misaligned), 0);
        access(1, 0, 0, 3'b000, 32'h13, 0); check("sbyte", o_read_data, 32'hFFFFFFDE);
        access(1, 0, 0, 3'b100, 32'h13, 0); check("ubyte", o_read_data, 32'h000000DE);
        access(1, 0, 0, 3'b001, 32'h10, 0); check("shalf", o_read_data, 32'hFFFFBEEF);
        access(1, 0, 0, 3'b101, 32'h12, 0); check("uhalf", o_read_data, 32'h0000DEAD);
        access(0, 1, 0, 3'b000, 32'h11, 32'h55);
        tick();
        access(1, 0, 0, 3'b011, 32'h10, 0); check("stall_store", o_read_data, 32'hDEADBEEF);
        access(0, 1, 1, 3'b000, 32'h11, 32'h55);
        tick();
        access(1, 0, 0, 3'b011, 32'h10, 0); check("byte_store", o_read_data, 32'hDEAD55EF);
        access(0, 1, 1, 3'b011, 32'h12, 32'h12345678);
        check("mis_store_flag", NB'(o_misaligned), 1);
        tick();
        access(1, 0, 0, 3'b011, 32'h10, 0); check("mis_store_drop", o_read_data, 32'hDEAD55EF);
        access(1, 0, 0, 3'b001, 32'h11, 0);
        check("mis_load_data", o_read_data, 0);
        check("mis_load_flag", NB'(o_misaligned), 1);
        access(0, 1, 1, 3'b011, 32'h0000_0410, 32'hCAFEF00D);
        tick();
        access(1, 0, 0, 3'b011, 32'h10, 0); check("wrap_store", o_read_data, 32'hCAFEF00D);

        repeat (400) begin
            logic [NB-1:0] a;
            logic [2:0]    ws;
            ws = 3'($urandom_range(0, 7));
            a  = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (ws[1:0] == 2'b11) a[1:0] = 2'b00;
                if (ws[1:0] == 2'b01) a[0]   = 1'b0;
            end
            i_branch = 1'($urandom_range(0, 1));
            i_cero   = 1'($urandom_range(0, 1));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ws, a, $urandom());
            tick();
        end

        i_branch = 0; i_cero = 0;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            access(0, 1, 1, 3'b011, NB'(4*k), NB'(k+1));
            tick();
        end
        access(0, 0, 0, 3'b011, 0, 0);

        i_dump_start = 1; tick(); i_dump_start = 0; tick();
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", NB'(o_dump_valid), 1);
            check("bp_data", o_dump_data, 32'd1);
            check("bp_addr", NB'(o_dump_addr), 0);
            tick();
        end
        i_dump_ready = 1;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            tick();
            if (o_dump_done) seen = 1;
        end
        check("dump_finished", NB'(seen), 1);
        tick();
        check("dump_busy_fall", NB'(o_dump_busy), 0);
        check("dump_words", NB'(exp_addr), NB'(MEM_DEPTH));
        check("done_pulses", NB'(done_cnt), 1);

        i_dump_start = 1; tick(); i_dump_start = 0;
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            i_dump_ready = 1'($urandom_range(0, 1));
            tick();
            if (exp_addr >= 6) seen = 1;
        end
        check("reach_word5", NB'(seen), 1);
        cnt0    = done_cnt;
        i_reset = 1;
        tick();
        check("abort_valid", NB'(o_dump_valid), 0);
        check("abort_busy", NB'(o_dump_busy), 0);
        i_reset = 0;
        repeat (10) tick();
        check("abort_no_done", NB'(done_cnt), NB'(cnt0));
        access(1, 0, 0, 3'b011, 32'h10, 0); check("reset_clears_mem", o_read_data, 0);

        i_branch = 1; i_cero = 1; #1; check("pc_src_taken", NB'(o_pc_src), 1);
        i_cero = 0; #1; check("pc_src_not", NB'(o_pc_src), 0);
        tick();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
